dac7821_write_seq: RTL and testbench
====================================

# dac7821_write_seq

Write sequencer for the DAC7821 parallel DACs, directly downstream of the CPU bus decode stage. It consumes the registered 12-bit DAC7821 chip-select decode and the pipelined CPU write data, and queues each CPU write in a small FIFO. It then replays each write as a timed DAC7821 parallel write cycle: data setup, chip-select pulse, then hold. The block runs on the 107 MHz system clock.

## Interface
Parameters:
- SETUP_CYC, 2, cycles DAC_DB/DAC_RNW are stable before DAC_NCS falls (1..15)
- CS_LOW_CYC, 3, cycles DAC_NCS is held low (1..15)
- HOLD_CYC, 2, cycles DAC_DB/DAC_RNW are held after DAC_NCS rises (1..15)
- FIFO_DEPTH, 4, write-queue entries (power of 2, 2..16)

Ports:
- Clock  in  1  system clock (107 MHz), all logic on rising edge
- Reset  in  1  one clock; reset is synchronous and active-low
- DEC_SEL  in  12  registered DAC7821 decode, one bit per device, level while CPU address held
- WR_DATA  in  12  CPU write data, low 12 bits of pipelined data bus, aligned with DEC_SEL
- CLR_FLAGS  in  1  single-cycle pulse, clears sticky flags
- DAC_DB  out  12  shared DAC data bus
- DAC_NCS  out  12  per-device chip select, active low
- DAC_RNW  out  1  shared R/W, low = write
- BUSY  out  1  high when FSM not IDLE or FIFO non-empty
- FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  current queue occupancy
- OVF_FLAG  out  1  sticky, a request was dropped on full FIFO
- MULTI_FLAG  out  1  sticky, a request had more than one DEC_SEL bit set

## Operation
- Request detect: keep a registered copy SEL_D of DEC_SEL. req = (|DEC_SEL) & ~(|SEL_D), i.e. a rising edge of "any select".
  - A held level produces exactly one request.
  - A change between two non-zero codes produces no request.
- On req, push {idx, WR_DATA} into the FIFO. idx is the lowest set bit of DEC_SEL.
  - More than one bit set: use the lowest set bit and set MULTI_FLAG.
- FIFO full on req with no pop in the same cycle: drop the request, set OVF_FLAG, leave contents unchanged.
- Full FIFO with push and pop in the same cycle: accept the push; level is unchanged.
- CLR_FLAGS clears both flags. If a flag-setting event occurs in the same cycle, the set wins.
- FSM states IDLE, SETUP, STROBE, HOLD. A 4-bit down-counter is loaded on each state entry.
  - IDLE: if the FIFO is non-empty, pop the head, register DAC_DB = data and the latched idx, drive DAC_RNW = 0, go to SETUP.
  - SETUP: lasts SETUP_CYC cycles, then go to STROBE with DAC_NCS[idx] = 0.
  - STROBE: lasts CS_LOW_CYC cycles, then go to HOLD with DAC_NCS = all 1.
  - HOLD: lasts HOLD_CYC cycles.
    - FIFO non-empty: pop, load new data/idx, go to SETUP; DAC_RNW stays 0.
    - Otherwise: go to IDLE with DAC_RNW = 1.
- At most one DAC_NCS bit is low at any time. DAC_DB changes only on entry to SETUP.
- Reset values (Reset = 0 at a rising edge), taking effect at that edge:
  - DAC_NCS = 12'hFFF, DAC_RNW = 1, DAC_DB = 0
  - FSM = IDLE, FIFO empty, FIFO_LEVEL = 0, SEL_D = 0
  - OVF_FLAG = 0, MULTI_FLAG = 0, BUSY = 0
- Reset asserted mid-transaction aborts it: NCS goes high at that edge and queued writes are discarded.
- After Reset releases with DEC_SEL already non-zero, a request is generated (SEL_D restarts at 0).

## Timing
- Edge E is the edge at which req is sampled.
- FIFO push occurs at E; FIFO_LEVEL updates after E.
- Idle-engine latency:
  - Pop at E+1: DAC_DB valid and DAC_RNW low after E+1.
  - DAC_NCS[idx] low after E+1+SETUP_CYC.
  - DAC_NCS high after E+1+SETUP_CYC+CS_LOW_CYC.
  - DAC_RNW high after E+1+SETUP_CYC+CS_LOW_CYC+HOLD_CYC.
- Per-write occupancy is SETUP_CYC+CS_LOW_CYC+HOLD_CYC cycles: 7 with defaults, about 65 ns.
- Back-to-back writes have no IDLE gap.
- All outputs are registered; no combinational path from inputs to outputs.
- With defaults, the sustained throughput is one write per 7 cycles. The CPU bus cycle is longer than this, so overflow only occurs under the test-plan burst stimulus.

## Test plan
- Reset check: hold Reset = 0 for 3 cycles with DEC_SEL = 12'h004 → DAC_NCS = 12'hFFF, DAC_RNW = 1, DAC_DB = 0, BUSY = 0. Release Reset → one write to device 2 occurs.
- Single write: DEC_SEL = 12'h010, WR_DATA = 12'hA5C, held 20 cycles → exactly one transaction. DAC_DB = 12'hA5C from E+1; DAC_NCS[4] low for exactly 3 cycles starting at E+3; DAC_RNW high again after E+8.
- Burst/queue: 5 requests, 1-cycle select pulses separated by 1 idle cycle, data 12'h001..12'h005, devices 0..4 → 5 contiguous 7-cycle transactions in order. DAC_RNW stays low throughout; FIFO_LEVEL peaks at 3 and returns to 0.
- Overflow: 7 pulse requests spaced 2 cycles apart → first 6 serviced, 7th dropped, OVF_FLAG = 1. A CLR_FLAGS pulse → OVF_FLAG = 0.
- Multi-select: DEC_SEL = 12'h0C0, WR_DATA = 12'h3FF → write to device 6 only, MULTI_FLAG = 1. A later change from 12'h040 directly to 12'h080 → no new request.
- Reset mid-operation: Reset = 0 during STROBE with 2 entries queued → DAC_NCS = 12'hFFF after that edge, FIFO_LEVEL = 0, no further transactions after release.

Source files
------------

// File: rtl/dac7821_write_seq.sv
// DAC7821 write sequencer: queues decoded CPU writes and replays each one as a timed
// parallel write cycle (data setup, chip-select pulse, hold) on a shared bus.
module dac7821_write_seq #(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned CS_LOW_CYC = 3,
  parameter int unsigned HOLD_CYC   = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [11:0]                   DEC_SEL,
  input  logic [11:0]                   WR_DATA,
  input  logic                          CLR_FLAGS,
  output logic [11:0]                   DAC_DB,
  output logic [11:0]                   DAC_NCS,
  output logic                          DAC_RNW,
  output logic                          BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic                          OVF_FLAG,
  output logic                          MULTI_FLAG
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] STROBE = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] CS_LD    = 4'(CS_LOW_CYC - 1);
  localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

  logic [11:0]      sel_d_q;
  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [15:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic [11:0]      db_q, db_d;
  logic [3:0]       idx_q, idx_d;
  logic [11:0]      ncs_q, ncs_d;
  logic             rnw_q, rnw_d;
  logic             busy_q, busy_d;
  logic             ovf_q, multi_q;

  logic        req, multi, push, pop, empty, full, ovf_set, multi_set;
  logic [3:0]  sel_idx;
  logic [15:0] head;

  assign req       = (|DEC_SEL) & ~(|sel_d_q);
  assign multi     = |(DEC_SEL & (DEC_SEL - 12'd1));
  assign empty     = (level_q == '0);
  assign full      = (level_q == LVL_W'(FIFO_DEPTH));
  assign head      = mem[rd_ptr_q];
  // A full queue still accepts a push when the engine pops in the same cycle.
  assign push      = req & (~full | pop);
  assign ovf_set   = req & full & ~pop;
  assign multi_set = req & multi;

  // Lowest set select bit wins.
  always_comb begin
    sel_idx = '0;
    for (int i = 11; i >= 0; i--) begin
      if (DEC_SEL[i]) sel_idx = 4'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    db_d    = db_q;
    idx_d   = idx_q;
    ncs_d   = ncs_q;
    rnw_d   = rnw_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          db_d    = head[11:0];
          idx_d   = head[15:12];
          rnw_d   = 1'b0;
          state_d = SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = CS_LD;
          ncs_d   = ~(12'd1 << idx_q);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
          ncs_d   = 12'hFFF;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (!empty) begin
          pop     = 1'b1;
          db_d    = head[11:0];
          idx_d   = head[15:12];
          state_d = SETUP;
          cnt_d   = SETUP_LD;
        end else begin
          state_d = IDLE;
          rnw_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LVL_W'(1);
    else if (!push && pop) level_d = level_q - LVL_W'(1);
    busy_d = (state_d != IDLE) | (level_d != '0);
  end

  always_ff @(posedge Clock) begin
    if (push) mem[wr_ptr_q] <= {sel_idx, WR_DATA};
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      sel_d_q  <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      db_q     <= '0;
      idx_q    <= '0;
      ncs_q    <= 12'hFFF;
      rnw_q    <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      multi_q  <= 1'b0;
    end else begin
      sel_d_q  <= DEC_SEL;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      db_q     <= db_d;
      idx_q    <= idx_d;
      ncs_q    <= ncs_d;
      rnw_q    <= rnw_d;
      busy_q   <= busy_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      // Set beats a simultaneous clear.
      ovf_q    <= ovf_set | (ovf_q & ~CLR_FLAGS);
      multi_q  <= multi_set | (multi_q & ~CLR_FLAGS);
    end
  end

  assign DAC_DB     = db_q;
  assign DAC_NCS    = ncs_q;
  assign DAC_RNW    = rnw_q;
  assign BUSY       = busy_q;
  assign FIFO_LEVEL = level_q;
  assign OVF_FLAG   = ovf_q;
  assign MULTI_FLAG = multi_q;

endmodule

// File: tb/tb_dac7821_write_seq.sv
// Bench for dac7821_write_seq: directed test-plan steps plus random traffic, checked every
// cycle against a transaction-timeline model (push time, start time, fixed write window).
module tb_dac7821_write_seq;

  localparam int SU    = 2;
  localparam int CL    = 3;
  localparam int HD    = 2;
  localparam int DEPTH = 4;
  localparam int TOT   = SU + CL + HD;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [11:0] DEC_SEL;
  logic [11:0] WR_DATA;
  logic        CLR_FLAGS;
  logic [11:0] DAC_DB;
  logic [11:0] DAC_NCS;
  logic        DAC_RNW;
  logic        BUSY;
  logic [2:0]  FIFO_LEVEL;
  logic        OVF_FLAG;
  logic        MULTI_FLAG;

  dac7821_write_seq #(
    .SETUP_CYC (SU),
    .CS_LOW_CYC(CL),
    .HOLD_CYC  (HD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .DEC_SEL   (DEC_SEL),
    .WR_DATA   (WR_DATA),
    .CLR_FLAGS (CLR_FLAGS),
    .DAC_DB    (DAC_DB),
    .DAC_NCS   (DAC_NCS),
    .DAC_RNW   (DAC_RNW),
    .BUSY      (BUSY),
    .FIFO_LEVEL(FIFO_LEVEL),
    .OVF_FLAG  (OVF_FLAG),
    .MULTI_FLAG(MULTI_FLAG)
  );

  always #5 Clock = ~Clock;

  // Accepted writes since the last reset: edge pushed, edge popped (write starts), target, data.
  int          m_push[$];
  int          m_start[$];
  logic [3:0]  m_idx[$];
  logic [11:0] m_dat[$];
  int          last_s;
  logic [11:0] m_seld;
  logic        m_ovf, m_multi;
  int          t;
  int          n_checks, n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s edge=%0d got=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit req, popping, ovf_set, multi_set;
    int cnt, s, lo;
    if (!Reset) begin
      m_push.delete(); m_start.delete(); m_idx.delete(); m_dat.delete();
      last_s = -1000; m_seld = '0; m_ovf = 1'b0; m_multi = 1'b0;
    end else begin
      req = (DEC_SEL != 12'd0) && (m_seld == 12'd0);
      cnt = 0; popping = 1'b0; ovf_set = 1'b0; multi_set = 1'b0;
      foreach (m_push[k]) begin
        if (m_push[k] < t && m_start[k] >= t) cnt++;
        if (m_start[k] == t) popping = 1'b1;
      end
      if (req) begin
        multi_set = ($countones(DEC_SEL) > 1);
        if (cnt == DEPTH && !popping) begin
          ovf_set = 1'b1;
        end else begin
          s = (t + 1 > last_s + TOT) ? t + 1 : last_s + TOT;
          last_s = s;
          lo = 0;
          for (int b = 11; b >= 0; b--) if (DEC_SEL[b]) lo = b;
          m_push.push_back(t); m_start.push_back(s);
          m_idx.push_back(4'(lo)); m_dat.push_back(WR_DATA);
        end
      end
      m_ovf   = ovf_set | (m_ovf & !CLR_FLAGS);
      m_multi = multi_set | (m_multi & !CLR_FLAGS);
      m_seld  = DEC_SEL;
    end
  endtask

  task automatic check_outputs();
    logic [11:0] e_db, e_ncs;
    logic        e_rnw, act;
    int          lvl;
    e_db = '0; e_ncs = 12'hFFF; e_rnw = 1'b1; act = 1'b0; lvl = 0;
    foreach (m_start[k]) begin
      if (m_start[k] <= t) e_db = m_dat[k];
      if (m_start[k] <= t && t < m_start[k] + TOT) begin
        act = 1'b1;
        e_rnw = 1'b0;
        if (t >= m_start[k] + SU && t < m_start[k] + SU + CL) e_ncs[m_idx[k]] = 1'b0;
      end
      if (m_push[k] <= t && m_start[k] > t) lvl++;
    end
    chk("db",    32'(DAC_DB),     32'(e_db));
    chk("ncs",   32'(DAC_NCS),    32'(e_ncs));
    chk("rnw",   32'(DAC_RNW),    32'(e_rnw));
    chk("level", 32'(FIFO_LEVEL), 32'(lvl));
    chk("busy",  32'(BUSY),       32'(act || lvl > 0));
    chk("ovf",   32'(OVF_FLAG),   32'(m_ovf));
    chk("multi", 32'(MULTI_FLAG), 32'(m_multi));
  endtask

  task automatic step();
    @(posedge Clock);
    t++;
    model_edge();
    #1;
    check_outputs();
  endtask

  initial begin
    int peak, nlow, r, hold;
    t = 0; n_checks = 0; n_fail = 0;
    last_s = -1000; m_seld = '0; m_ovf = 1'b0; m_multi = 1'b0;

    // Reset held with a select already present, then released.
    Reset = 1'b0; DEC_SEL = 12'h004; WR_DATA = 12'h123; CLR_FLAGS = 1'b0;
    repeat (3) step();
    chk("rst_ncs",  32'(DAC_NCS), 32'h0000_0FFF);
    chk("rst_rnw",  32'(DAC_RNW), 32'd1);
    chk("rst_db",   32'(DAC_DB),  32'd0);
    chk("rst_busy", 32'(BUSY),    32'd0);
    Reset = 1'b1;
    nlow = 0;
    repeat (12) begin
      step();
      if (DAC_NCS == 12'hFFB) nlow++;
    end
    chk("rst_release_dev2", 32'(nlow), 32'(CL));
    DEC_SEL = 12'h000;
    repeat (3) step();

    // Single held write.
    DEC_SEL = 12'h010; WR_DATA = 12'hA5C;
    repeat (20) step();
    chk("single_db", 32'(DAC_DB), 32'h0000_0A5C);
    DEC_SEL = 12'h000;
    repeat (3) step();

    // Burst of five pulses.
    peak = 0;
    for (int i = 0; i < 5; i++) begin
      DEC_SEL = 12'(1 << i); WR_DATA = 12'(i + 1);
      step();
      if (int'(FIFO_LEVEL) > peak) peak = int'(FIFO_LEVEL);
      DEC_SEL = 12'h000;
      step();
      if (int'(FIFO_LEVEL) > peak) peak = int'(FIFO_LEVEL);
    end
    repeat (40) begin
      step();
      if (int'(FIFO_LEVEL) > peak) peak = int'(FIFO_LEVEL);
    end
    chk("burst_peak", 32'(peak), 32'd3);
    chk("burst_drain", 32'(FIFO_LEVEL), 32'd0);

    // Overflow: seventh pulse finds the queue full.
    for (int i = 0; i < 7; i++) begin
      DEC_SEL = 12'(1 << i); WR_DATA = 12'(12'h100 + i);
      step();
      DEC_SEL = 12'h000;
      step();
    end
    chk("ovf_set", 32'(OVF_FLAG), 32'd1);
    repeat (50) step();
    CLR_FLAGS = 1'b1;
    step();
    CLR_FLAGS = 1'b0;
    step();
    chk("ovf_clr", 32'(OVF_FLAG), 32'd0);

    // Multi-select, then a non-zero to non-zero change.
    DEC_SEL = 12'h0C0; WR_DATA = 12'h3FF;
    repeat (3) step();
    DEC_SEL = 12'h000;
    step();
    chk("multi_set", 32'(MULTI_FLAG), 32'd1);
    DEC_SEL = 12'h040; WR_DATA = 12'h111;
    repeat (2) step();
    DEC_SEL = 12'h080; WR_DATA = 12'h222;
    repeat (3) step();
    DEC_SEL = 12'h000;
    repeat (30) step();
    chk("no_req_on_change", 32'(DAC_DB), 32'h0000_0111);

    // Reset during a strobe with two writes queued.
    for (int i = 0; i < 3; i++) begin
      DEC_SEL = 12'(1 << (i + 8)); WR_DATA = 12'(12'h700 + i);
      step();
      DEC_SEL = 12'h000;
      if (i < 2) step();
    end
    chk("pre_rst_level", 32'(FIFO_LEVEL), 32'd2);
    chk("pre_rst_strobe", 32'(DAC_NCS), 32'h0000_0EFF);
    Reset = 1'b0;
    step();
    chk("midrst_ncs",   32'(DAC_NCS),    32'h0000_0FFF);
    chk("midrst_level", 32'(FIFO_LEVEL), 32'd0);
    Reset = 1'b1;
    nlow = 0;
    repeat (30) begin
      step();
      if (DAC_NCS != 12'hFFF) nlow++;
    end
    chk("midrst_no_txn", 32'(nlow), 32'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6)      DEC_SEL = 12'h000;
      else if (r < 8) DEC_SEL = 12'(1 << $urandom_range(0, 11));
      else            DEC_SEL = 12'($urandom);
      WR_DATA   = 12'($urandom);
      CLR_FLAGS = ($urandom_range(0, 15) == 0);
      Reset     = ($urandom_range(0, 199) != 0);
      hold = int'($urandom_range(1, 4));
      repeat (hold) step();
    end
    Reset = 1'b1; DEC_SEL = 12'h000; CLR_FLAGS = 1'b0;
    repeat (40) step();
    chk("final_idle", 32'(BUSY), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
